// File: rtl/stage_if_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface stage_if_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [34:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/stage_if.sv
// Instruction fetch stage: PC generation, in-order imem requests, PC-tagged fetch queue.
// Optional IF_RESP_BYPASS_EN: a response that fills the queue head drives the output in the same cycle.
module stage_if #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [34:0] NOP_INST = 35'h000000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  stage_if_if.master  imem,
  output logic        if_valid,
  output logic [34:0] if_inst,
  output logic [31:0] if_pc
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  // Responses still owed by memory for discarded fetches; sized for several back-to-back redirects.
  localparam int unsigned DW = AW + 4;

  logic [31:0]      pc;
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DW-1:0]    drop_cnt;
  logic [DEPTH-1:0] filled;
  logic [31:0]      pc_q   [DEPTH];
  logic [34:0]      inst_q [DEPTH];

  logic [PW-1:0] count;
  logic [PW-1:0] out_cnt;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] rd_idx;
  logic          issue;
  logic          rv_drop;
  logic          rv_fill;
  logic          head_filled;
  logic          bp_hit;
  logic          consume;

  assign count     = alloc_ptr - rd_ptr;
  assign out_cnt   = alloc_ptr - fill_ptr;
  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];

  // Fullness is judged on the pre-consume count, so a full queue never issues.
  assign imem.imem_req  = !rst && (count != PW'(DEPTH)) && !br_redirect;
  assign imem.imem_addr = pc;
  assign issue          = imem.imem_req && imem.imem_ready;

  assign rv_drop     = imem.imem_rvalid && (drop_cnt != '0);
  assign rv_fill     = imem.imem_rvalid && (drop_cnt == '0) && (out_cnt != '0);
  assign head_filled = (count != '0) && filled[rd_idx];

`ifdef IF_RESP_BYPASS_EN
  assign bp_hit = rv_fill && (fill_ptr == rd_ptr) && !br_redirect;
`else
  assign bp_hit = 1'b0;
`endif

  assign if_valid = head_filled || bp_hit;
  assign if_inst  = head_filled ? inst_q[rd_idx] : (bp_hit ? imem.imem_rdata : NOP_INST);
  assign if_pc    = (count != '0) ? pc_q[rd_idx] : pc;
  assign consume  = if_valid && !ctrl_stall && !br_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (br_redirect) begin
      // Every unfilled entry still has a response coming; one arriving now is already discarded.
      pc        <= br_target & 32'hFFFF_FFFC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= drop_cnt + DW'(out_cnt) - DW'(rv_drop || rv_fill);
    end else begin
      if (issue) begin
        alloc_ptr         <= alloc_ptr + PW'(1);
        pc                <= pc + 32'd4;
        filled[alloc_idx] <= 1'b0;
      end
      if (rv_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      if (rv_fill) begin
        fill_ptr <= fill_ptr + PW'(1);
        if (!(bp_hit && consume)) begin
          filled[fill_idx] <= 1'b1;
        end
      end
      if (consume) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pc_q[alloc_idx] <= pc;
    end
    if (rv_fill && !br_redirect) begin
      inst_q[fill_idx] <= imem.imem_rdata;
    end
  end

`ifndef SYNTHESIS
  a_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
    imem.imem_rvalid |-> ((drop_cnt != '0) || (out_cnt != '0)));
`endif

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: in-order variable-latency memory model plus a queue-level reference model.
module tb_stage_if;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [34:0] NOP      = 35'h000000013;
`ifdef IF_RESP_BYPASS_EN
  localparam int LAT_OUT = 0;
`else
  localparam int LAT_OUT = 1;
`endif
  localparam int FV = 2 + LAT_OUT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_stall = 1'b0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        if_valid;
  logic [34:0] if_inst;
  logic [31:0] if_pc;

  stage_if_if bus();

  stage_if #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_stall (ctrl_stall),
    .br_redirect(br_redirect),
    .br_target  (br_target),
    .imem       (bus),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  typedef struct { logic [31:0] pc; logic [34:0] inst; bit filled; } ent_t;
  ent_t        fq[$];
  logic [31:0] m_pc;
  int          m_drop;
  int          m_nfill;

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  int   mem_last_due;
  int   lat_min = 1;
  int   lat_max = 1;

  logic         exp_req, exp_valid;
  logic [31:0]  exp_addr, exp_pc;
  logic [34:0]  exp_inst;
  logic [100:0] obs_v, exp_v;

  function automatic logic [34:0] mk_data(input logic [31:0] a);
    return {a[4:2], a ^ 32'h5A5A_0013};
  endfunction

  task automatic model_reset();
    fq.delete();
    mq.delete();
    m_pc = RESET_PC;
    m_drop = 0;
    mem_last_due = 0;
    cyc = 1;
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst = 1'b1;
    ctrl_stall = 1'b0;
    br_redirect = 1'b0;
    br_target = 32'h0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs at the falling edge and derive the expected outputs.
  task automatic cyc_begin(input bit stall, input bit redir, input logic [31:0] tgt, input bit rdy);
    @(negedge clk);
    ctrl_stall = stall;
    br_redirect = redir;
    br_target = tgt;
    bus.imem_ready = rdy;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = mk_data(mq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = {3'($urandom_range(7, 0)), 32'($urandom)};
    end
    #1;
    m_nfill = 0;
    while (m_nfill < fq.size() && fq[m_nfill].filled) m_nfill++;
    exp_req   = (fq.size() < DEPTH) && !redir;
    exp_addr  = m_pc;
    exp_valid = (m_nfill > 0);
    exp_inst  = (m_nfill > 0) ? fq[0].inst : NOP;
`ifdef IF_RESP_BYPASS_EN
    if (m_nfill == 0 && fq.size() > 0 && bus.imem_rvalid && m_drop == 0 && !redir) begin
      exp_valid = 1'b1;
      exp_inst  = bus.imem_rdata;
    end
`endif
    exp_pc = (fq.size() > 0) ? fq[0].pc : m_pc;
    exp_v = {exp_req, exp_addr, exp_valid, exp_inst, exp_pc};
    obs_v = {bus.imem_req, bus.imem_addr, if_valid, if_inst, if_pc};
  endtask

  // Advance the memory and the reference queue by the events of this cycle, then take the clock edge.
  task automatic cyc_end();
    int unf;
    int due;
    bit rv;
    unf = fq.size() - m_nfill;
    rv  = bus.imem_rvalid;
    if (rv) void'(mq.pop_front());
    if (bus.imem_req && bus.imem_ready) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= mem_last_due) due = mem_last_due + 1;
      mq.push_back('{bus.imem_addr, due});
      mem_last_due = due;
    end
    if (br_redirect) begin
      m_drop = m_drop + unf - ((rv && (m_drop > 0 || unf > 0)) ? 1 : 0);
      fq.delete();
      m_pc = {br_target[31:2], 2'b00};
    end else begin
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (unf > 0) begin
          fq[m_nfill].inst   = bus.imem_rdata;
          fq[m_nfill].filled = 1'b1;
        end
      end
      if (exp_valid && !ctrl_stall) void'(fq.pop_front());
      if (exp_req && bus.imem_ready) begin
        fq.push_back('{m_pc, NOP, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    reset_assert();
    n_checks++;
    if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_ctrl got req=%b valid=%b want req=0 valid=0", bus.imem_req, if_valid);
    end
    n_checks++;
    if (if_inst !== NOP) begin
      n_errors++; $display("FAIL reset_inst got=%h want=%h", if_inst, NOP);
    end
    n_checks++;
    if (if_pc !== RESET_PC || bus.imem_addr !== RESET_PC) begin
      n_errors++; $display("FAIL reset_pc got pc=%h addr=%h want=%h", if_pc, bus.imem_addr, RESET_PC);
    end
    reset_release();
    cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      n_errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
    cyc_end();
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 14; c++) begin
      cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL stream_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c >= FV) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (c - FV)) || if_inst !== mk_data(32'(4 * (c - FV)))) begin
          n_errors++; $display("FAIL stream_seq cyc=%0d got valid=%b pc=%h want valid=1 pc=%h", c, if_valid, if_pc, 32'(4 * (c - FV)));
        end
      end
      cyc_end();
    end
  endtask

  task automatic test_stall();
    logic [31:0] want;
    lat_min = 1; lat_max = 1;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 20; c++) begin
      cyc_begin(c >= 7 && c <= 11, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL stall_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c >= FV) begin
        if (c < 7)       want = 32'(4 * (c - FV));
        else if (c <= 12) want = 32'(4 * (7 - FV));
        else             want = 32'(4 * (7 - FV) + 4 * (c - 12));
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== want || if_inst !== mk_data(want)) begin
          n_errors++; $display("FAIL stall_seq cyc=%0d got valid=%b pc=%h want valid=1 pc=%h", c, if_valid, if_pc, want);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
          n_errors++; $display("FAIL stall_full_req got=%b want=0", bus.imem_req);
        end
      end
      cyc_end();
    end
  endtask

  task automatic test_redirect();
    bit seen = 0;
    lat_min = 3; lat_max = 3;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 20; c++) begin
      cyc_begin(1'b0, c == 4, 32'h100, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL redir_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
          n_errors++; $display("FAIL redir_req got=%b want=0", bus.imem_req);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (bus.imem_addr !== 32'h100 || if_valid !== 1'b0) begin
          n_errors++; $display("FAIL redir_next got addr=%h valid=%b want addr=00000100 valid=0", bus.imem_addr, if_valid);
        end
      end
      if (if_valid === 1'b1) begin
        n_checks++;
        if (if_pc < 32'h100 || if_inst !== mk_data(if_pc) || (!seen && if_pc !== 32'h100)) begin
          n_errors++; $display("FAIL redir_out cyc=%0d got pc=%h inst=%h want pc>=00000100 first=00000100", c, if_pc, if_inst);
        end
        seen = 1;
      end
      cyc_end();
    end
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL redir_timeout got no valid want valid at pc 00000100");
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] held;
    held = 32'(4 * (6 - FV));
    lat_min = 1; lat_max = 1;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 14; c++) begin
      cyc_begin(c == 6 || c == 7, c == 7, 32'h100, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL rs_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c == 7) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== held || bus.imem_req !== 1'b0) begin
          n_errors++; $display("FAIL rs_cycle got valid=%b pc=%h req=%b want valid=1 pc=%h req=0", if_valid, if_pc, bus.imem_req, held);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (bus.imem_addr !== 32'h100 || if_valid !== 1'b0 || if_pc !== 32'h100) begin
          n_errors++; $display("FAIL rs_next got addr=%h valid=%b pc=%h want addr=00000100 valid=0 pc=00000100", bus.imem_addr, if_valid, if_pc);
        end
      end
      if (c > 7 && if_valid === 1'b1) begin
        n_checks++;
        if (if_pc < 32'h100) begin
          n_errors++; $display("FAIL rs_discard cyc=%0d got pc=%h want pc>=00000100", c, if_pc);
        end
      end
      cyc_end();
    end
  endtask

  task automatic test_ready_low();
    lat_min = 1; lat_max = 1;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 9; c++) begin
      cyc_begin(1'b0, 1'b0, 32'h0, c == 5);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL rdy_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== ((c <= 5) ? 32'h0 : 32'h4)) begin
        n_errors++; $display("FAIL rdy_addr cyc=%0d got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req, bus.imem_addr, (c <= 5) ? 32'h0 : 32'h4);
      end
      if (c <= 5 + LAT_OUT) begin
        n_checks++;
        if (if_valid !== 1'b0 || if_inst !== NOP) begin
          n_errors++; $display("FAIL rdy_empty cyc=%0d got valid=%b inst=%h want valid=0 inst=%h", c, if_valid, if_inst, NOP);
        end
      end
      if (c == 6 + LAT_OUT) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
          n_errors++; $display("FAIL rdy_first got valid=%b pc=%h want valid=1 pc=00000000", if_valid, if_pc);
        end
      end
      cyc_end();
    end
  endtask

  task automatic test_reset_mid();
    lat_min = 8; lat_max = 8;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 7; c++) begin
      cyc_begin(c >= 4, c == 3, 32'h200, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL rmid_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      cyc_end();
    end
    cyc_begin(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h210 || if_pc !== 32'h200) begin
      n_errors++; $display("FAIL rmid_full got req=%b addr=%h pc=%h want req=0 addr=00000210 pc=00000200", bus.imem_req, bus.imem_addr, if_pc);
    end
    rst = 1'b1;
    ctrl_stall = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || if_valid !== 1'b0 || if_inst !== NOP || if_pc !== RESET_PC || bus.imem_addr !== RESET_PC) begin
      n_errors++; $display("FAIL rmid_reset got req=%b valid=%b inst=%h pc=%h want 0 0 %h %h", bus.imem_req, if_valid, if_inst, if_pc, NOP, RESET_PC);
    end
    model_reset();
    lat_min = 1; lat_max = 1;
    reset_release();
    for (int c = 1; c <= 10; c++) begin
      cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL rmid_restart_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c >= FV) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (c - FV))) begin
          n_errors++; $display("FAIL rmid_restart cyc=%0d got valid=%b pc=%h want valid=1 pc=%h", c, if_valid, if_pc, 32'(4 * (c - FV)));
        end
      end
      cyc_end();
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    reset_assert();
    reset_release();
    for (int c = 1; c <= 400; c++) begin
      cyc_begin($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, 32'($urandom), $urandom_range(9, 0) < 7);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++; $display("FAIL rand_model cyc=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (if_valid === 1'b1) begin
        n_checks++;
        if (if_inst !== mk_data(if_pc) || if_pc[1:0] !== 2'b00) begin
          n_errors++; $display("FAIL rand_data cyc=%0d got pc=%h inst=%h want inst=%h", c, if_pc, if_inst, mk_data(if_pc));
        end
      end
      cyc_end();
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_ready_low();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
